// File: rtl/equiv_sweep_ctrl.sv
// rtl/equiv_sweep_ctrl.sv - exhaustive equivalence sweep sequencer for two combinational circuits
//
// Drives every input vector onto a bus shared by an original and a minimized
// circuit, holds each vector for SETTLE cycles, then samples both F outputs.
// Captures both truth tables, counts mismatches and records the first failing vector.
//
// Ports:
//   clk, rst      - clock (rising edge), synchronous active-high reset
//   start         - launch a sweep (only honoured in IDLE)
//   vec           - vector driven to both circuits
//   f_orig, f_min - circuit outputs, sampled once per vector
//   busy, done    - sweep in progress / one-cycle completion pulse
//   pass          - set after completion when no mismatches were seen
//   mismatch_cnt  - number of mismatching vectors (wide enough for all of them)
//   fail_valid    - at least one mismatch recorded
//   first_fail    - lowest-index mismatching vector
//   tt_orig/min   - captured truth tables, bit i = F at vec = i
module equiv_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 f_orig,
    input  logic                 f_min,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic                 fail_valid,
    output logic [N_IN-1:0]      first_fail,
    output logic [2**N_IN-1:0]   tt_orig,
    output logic [2**N_IN-1:0]   tt_min
);

    localparam int              NV          = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(NV - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        FIN
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] settle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                busy = 1'b1;
                // Counter still holds the pre-increment value, so the last
                // HOLD cycle is the one where it reads SETTLE-1.
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (vec == LAST_VEC) begin
                    state_d = FIN;
                end else begin
                    state_d = HOLD;
                end
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec          <= '0;
            settle_cnt   <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
            tt_orig      <= '0;
            tt_min       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    vec        <= '0;
                    settle_cnt <= '0;
                    if (start) begin
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                        fail_valid   <= 1'b0;
                        first_fail   <= '0;
                        tt_orig      <= '0;
                        tt_min       <= '0;
                    end
                end
                HOLD: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    tt_orig[vec] <= f_orig;
                    tt_min[vec]  <= f_min;
                    if (f_orig != f_min) begin
                        mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            first_fail <= vec;
                        end
                    end
                    settle_cnt <= '0;
                    // vec stays on the last vector through FIN; no wrap mid-sweep.
                    if (vec != LAST_VEC) begin
                        vec <= vec + N_IN'(1);
                    end
                end
                FIN: begin
                    // mismatch_cnt already includes the final sample here.
                    pass <= (mismatch_cnt == '0);
                    vec  <= '0;
                end
                default: begin
                    vec <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// tb/tb_equiv_sweep_ctrl.sv - directed self-checking bench for equiv_sweep_ctrl
module tb_equiv_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start0, start1;
    logic [2:0] vec0, vec1;
    logic       f_orig0, f_min0, f_orig1, f_min1;
    logic       busy0, done0, pass0, fail_valid0;
    logic       busy1, done1, pass1, fail_valid1;
    logic [3:0] cnt0, cnt1;
    logic [2:0] first_fail0, first_fail1;
    logic [7:0] tt_orig0, tt_min0, tt_orig1, tt_min1;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    equiv_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .vec(vec0),
        .f_orig(f_orig0), .f_min(f_min0), .busy(busy0), .done(done0),
        .pass(pass0), .mismatch_cnt(cnt0), .fail_valid(fail_valid0),
        .first_fail(first_fail0), .tt_orig(tt_orig0), .tt_min(tt_min0)
    );

    equiv_sweep_ctrl #(.N_IN(3), .SETTLE(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec(vec1),
        .f_orig(f_orig1), .f_min(f_min1), .busy(busy1), .done(done1),
        .pass(pass1), .mismatch_cnt(cnt1), .fail_valid(fail_valid1),
        .first_fail(first_fail1), .tt_orig(tt_orig1), .tt_min(tt_min1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Original: F = AB + AB'C ; minimized: F = A(B+C). A = vec[2], C = vec[0].
    function automatic logic f_o(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & ~v[1] & v[0]);
    endfunction

    function automatic logic f_m(input logic [2:0] v);
        return v[2] & (v[1] | v[0]);
    endfunction

    always_comb begin
        f_orig0 = f_o(vec0);
        f_orig1 = f_o(vec1);
        f_min1  = f_m(vec1);
        case (mode)
            1:       f_min0 = vec0[2] & vec0[1];
            2:       f_min0 = 1'b0;
            3:       f_min0 = ~f_o(vec0);
            default: f_min0 = f_m(vec0);
        endcase
    end

    // Launches one sweep and records when done pulses and whether vec follows
    // the expected hold pattern (vector t/(settle+1) at cycle t after accept).
    task automatic do_sweep(input int sel, input int settle, input bit pulse_mid,
                            output int done_at, output int pulses, output int vec_errs);
        logic [2:0] v;
        logic       d, b;
        done_at  = -1;
        pulses   = 0;
        vec_errs = 0;
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int t = 0; t < 200; t++) begin
            v = (sel == 0) ? vec0 : vec1;
            d = (sel == 0) ? done0 : done1;
            b = (sel == 0) ? busy0 : busy1;
            if (t < 8 * (settle + 1) && v !== 3'(t / (settle + 1))) vec_errs++;
            if (d === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = t;
            end
            if (b !== 1'b1 && done_at >= 0) break;
            if (pulse_mid && t == 5) start0 = 1'b1;
            if (pulse_mid && t == 6) start0 = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({busy0, done0, pass0, cnt0, fail_valid0, first_fail0, tt_orig0, tt_min0, vec0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b cnt=%0d fv=%b ff=%0d tto=%h ttm=%h vec=%0d want all 0",
                     busy0, done0, pass0, cnt0, fail_valid0, first_fail0, tt_orig0, tt_min0, vec0);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep(input int m, input logic [7:0] exp_ttm, input logic [3:0] exp_cnt,
                              input logic exp_fv, input logic [2:0] exp_ff, input bit pulse_mid);
        int done_at, pulses, vec_errs;
        mode = m;
        do_sweep(0, 1, pulse_mid, done_at, pulses, vec_errs);
        checks++;
        if (done_at != 16 || pulses != 1) begin
            failures++;
            $display("FAIL sweep_timing mode=%0d got done_at=%0d pulses=%0d want 16/1", m, done_at, pulses);
        end
        checks++;
        if (vec_errs != 0) begin
            failures++;
            $display("FAIL sweep_vec_seq mode=%0d got %0d bad cycles want 0", m, vec_errs);
        end
        checks++;
        if (tt_orig0 !== 8'hE0 || tt_min0 !== exp_ttm) begin
            failures++;
            $display("FAIL sweep_tt mode=%0d got orig=%h min=%h want E0/%h", m, tt_orig0, tt_min0, exp_ttm);
        end
        checks++;
        if (cnt0 !== exp_cnt || fail_valid0 !== exp_fv || first_fail0 !== exp_ff
            || pass0 !== (exp_cnt == 4'd0)) begin
            failures++;
            $display("FAIL sweep_result mode=%0d got cnt=%0d fv=%b ff=%0d pass=%b want %0d/%b/%0d/%b",
                     m, cnt0, fail_valid0, first_fail0, pass0, exp_cnt, exp_fv, exp_ff, exp_cnt == 4'd0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        mode = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
        end
        // now in the 6th busy cycle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy0, done0, pass0, cnt0, fail_valid0, first_fail0, tt_orig0, tt_min0, vec0} !== '0) begin
            failures++;
            $display("FAIL reset_mid_sweep got busy=%b cnt=%0d fv=%b ff=%0d tto=%h ttm=%h vec=%0d want all 0",
                     busy0, cnt0, fail_valid0, first_fail0, tt_orig0, tt_min0, vec0);
        end
        @(posedge clk); #1;
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle got busy=%b want 0", busy0);
        end
    endtask

    task automatic test_settle3();
        int done_at, pulses, vec_errs;
        do_sweep(1, 3, 1'b0, done_at, pulses, vec_errs);
        checks++;
        if (done_at != 32 || pulses != 1 || vec_errs != 0) begin
            failures++;
            $display("FAIL settle3_timing got done_at=%0d pulses=%0d vec_errs=%0d want 32/1/0",
                     done_at, pulses, vec_errs);
        end
        checks++;
        if (tt_orig1 !== 8'hE0 || tt_min1 !== 8'hE0 || cnt1 !== 4'd0 || pass1 !== 1'b1
            || fail_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL settle3_result got tto=%h ttm=%h cnt=%0d pass=%b fv=%b want E0/E0/0/1/0",
                     tt_orig1, tt_min1, cnt1, pass1, fail_valid1);
        end
    endtask

    task automatic test_back_to_back();
        int done_at;
        mode    = 0;
        done_at = -1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 40 && done_at < 0; t++) begin
            if (done0 === 1'b1) done_at = t;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (done_at != 16) begin
            failures++;
            $display("FAIL b2b_first_done got %0d want 16", done_at);
        end
        @(posedge clk); #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle_gap got busy=%b done=%b pass=%b want 0/0/1", busy0, done0, pass0);
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || vec0 !== 3'd0 || pass0 !== 1'b0 || tt_orig0 !== 8'h00) begin
            failures++;
            $display("FAIL b2b_relaunch got busy=%b vec=%0d pass=%b tto=%h want 1/0/0/00",
                     busy0, vec0, pass0, tt_orig0);
        end
        for (int t = 0; t < 40 && busy0 === 1'b1; t++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (tt_orig0 !== 8'hE0 || pass0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_result got tto=%h pass=%b want E0/1", tt_orig0, pass0);
        end
    endtask

    initial begin
        start0 = 1'b0;
        start1 = 1'b0;
        rst    = 1'b0;
        test_reset();
        test_sweep(0, 8'hE0, 4'd0, 1'b0, 3'd0, 1'b0);
        test_sweep(1, 8'hC0, 4'd1, 1'b1, 3'd5, 1'b0);
        test_sweep(2, 8'h00, 4'd3, 1'b1, 3'd5, 1'b0);
        test_sweep(3, 8'h1F, 4'd8, 1'b1, 3'd0, 1'b0);
        test_reset_mid_sweep();
        test_sweep(0, 8'hE0, 4'd0, 1'b0, 3'd0, 1'b0);
        test_sweep(1, 8'hC0, 4'd1, 1'b1, 3'd5, 1'b1);
        test_settle3();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
